// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | line high, waiting for data_valid; counters held at 0
// START  | start bit (line low)
// DATA   | data bits, shadow[bit_cnt], LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (line high)
module uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int EW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [EW-1:0] EDGE_LAST = EW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]            state, state_nxt;
   logic [EW-1:0]         edge_cnt, edge_nxt;
   logic [BW-1:0]         bit_cnt, bit_nxt;
   logic [DATA_WIDTH-1:0] shadow, shadow_nxt;
   logic                  line_nxt;
   logic                  wrap;

`ifdef UART_TX_PARITY_EN
   logic par_en_q, par_typ_q;
   logic par_bit;

   assign par_bit = (^shadow) ^ par_typ_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (state == S_IDLE && data_valid) begin
         par_en_q  <= par_en;
         par_typ_q <= par_typ;
      end
   end
`else
   logic unused_par;
   assign unused_par = par_en ^ par_typ;
`endif

   assign wrap = (edge_cnt == EDGE_LAST);

   always_comb begin
      state_nxt  = state;
      edge_nxt   = edge_cnt;
      bit_nxt    = bit_cnt;
      shadow_nxt = shadow;
      case (state)
         S_IDLE: begin
            edge_nxt = '0;
            bit_nxt  = '0;
            if (data_valid) begin
               state_nxt  = S_START;
               shadow_nxt = p_data;
            end
         end
         S_START: begin
            if (wrap) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (wrap) begin
               if (bit_cnt == BIT_LAST) begin
                  bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = par_en_q ? S_PARITY : S_STOP;
`else
                  state_nxt = S_STOP;
`endif
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (wrap) state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (wrap) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (state != S_IDLE) edge_nxt = wrap ? '0 : edge_cnt + 1'b1;
   end

   // The line is registered from the next-state view so each bit appears on the edge that enters it.
   always_comb begin
      line_nxt = 1'b1;
      case (state_nxt)
         S_START:  line_nxt = 1'b0;
         S_DATA:   line_nxt = shadow_nxt[bit_nxt];
`ifdef UART_TX_PARITY_EN
         S_PARITY: line_nxt = par_bit;
`endif
         default:  line_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
         shadow   <= '0;
         tx_out   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         edge_cnt <= edge_nxt;
         bit_cnt  <= bit_nxt;
         shadow   <= shadow_nxt;
         tx_out   <= line_nxt;
         busy     <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4); line monitor checks frames against a queue.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILD = 1'b1;
`else
   localparam bit PAR_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] p_data = 8'h00;
   logic       data_valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx_out;
   logic       busy;

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         par;
      bit         pbit;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      bit         pe;
      bit         pt;
      bit         exp_pbit;
   } vec_t;

   frame_t exp_q[$];
   int     total = 0;
   int     passed = 0;
   bit     armed = 1'b0;
   bit     in_frame = 1'b0;
   int     frames_seen = 0;
   int     idle_cnt = 0;
   int     last_gap = 0;
   int     idle_bad = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic push(input logic [7:0] d, input bit pe, input bit pb);
      frame_t f;
      f.data = d;
      f.par  = PAR_BUILD && pe;
      f.pbit = pb;
      exp_q.push_back(f);
   endtask

   // monitor: samples the line on every falling edge
   initial begin
      frame_t cur;
      bit     bitsv[11];
      int     k, nb, bad;
      bit     has_exp;
      k = 0; nb = 10; bad = 0;
      forever begin
         @(negedge clk);
         if (!armed) continue;
         if (!rst) begin
            if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
            idle_cnt = 0;
         end else if (busy) begin
            if (!in_frame) begin
               in_frame = 1'b1;
               k = 0;
               bad = 0;
               last_gap = idle_cnt;
               frames_seen++;
               has_exp = (exp_q.size() > 0);
               check("frame_expected", int'(has_exp), 1);
               if (has_exp) cur = exp_q.pop_front();
               else begin
                  cur.data = 8'h00; cur.par = 1'b0; cur.pbit = 1'b0;
               end
               bitsv[0] = 1'b0;
               for (int i = 0; i < 8; i++) bitsv[i+1] = cur.data[i];
               if (cur.par) begin
                  bitsv[9] = cur.pbit; bitsv[10] = 1'b1; nb = 11;
               end else begin
                  bitsv[9] = 1'b1; bitsv[10] = 1'b1; nb = 10;
               end
            end
            if (k / CPB >= nb) bad++;
            else if (tx_out !== bitsv[k / CPB]) bad++;
            k++;
         end else begin
            if (in_frame) begin
               in_frame = 1'b0;
               check("frame_bits", bad, 0);
               check("frame_len", k, nb * CPB);
               idle_cnt = 0;
            end
            idle_cnt++;
            if (tx_out !== 1'b1) idle_bad++;
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit pe, input bit pt, input bit pb);
      @(negedge clk);
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      push(d, pe, pb);
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk); #1;
         if (!busy && !in_frame && exp_q.size() == 0) done = 1'b1;
      end
      check("drain_timeout", int'(done), 1);
   endtask

   task automatic wait_busy(input bit val);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk); #1;
         if (busy == val) hit = 1'b1;
      end
      check("busy_wait_timeout", int'(hit), 1);
   endtask

   initial begin
      vec_t vecs[7];
      int   fs;
      vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, exp_pbit: 1'b0};
      vecs[1] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, exp_pbit: 1'b1};
      vecs[2] = '{data: 8'h07, pe: 1'b1, pt: 1'b1, exp_pbit: 1'b0};
      vecs[3] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, exp_pbit: 1'b0};
      vecs[4] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, exp_pbit: 1'b1};
      vecs[5] = '{data: 8'h80, pe: 1'b1, pt: 1'b0, exp_pbit: 1'b1};
      vecs[6] = '{data: 8'hFF, pe: 1'b0, pt: 1'b1, exp_pbit: 1'b0};

      // reset asserted between edges
      #12 rst = 1'b0;
      #1;
      check("reset_tx_out", int'(tx_out), 1);
      check("reset_busy", int'(busy), 0);
      @(negedge clk); #1 rst = 1'b1;
      armed = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_tx_out", int'(tx_out), 1);
      check("post_reset_busy", int'(busy), 0);

      // accept latency: line low and busy high right after the accepting edge
      @(negedge clk);
      p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      push(8'hA5, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("accept_tx_out", int'(tx_out), 0);
      check("accept_busy", int'(busy), 1);
      @(negedge clk);
      data_valid = 1'b0;
      wait_done();

      for (int v = 0; v < 7; v++) begin
         send(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].exp_pbit);
         wait_done();
      end

      // request and config changes mid-frame are ignored
      send(8'h3C, 1'b1, 1'b0, 1'b0);
      repeat (12) @(negedge clk);
      p_data = 8'hFF; par_typ = 1'b1; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      wait_done();
      fs = frames_seen;
      repeat (30) @(negedge clk);
      check("no_second_frame", frames_seen, fs);

      // continuous data_valid: one idle cycle between frames
      @(negedge clk);
      p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      push(8'h55, 1'b0, 1'b0);
      wait_busy(1'b1);
      p_data = 8'hAA;
      push(8'hAA, 1'b0, 1'b0);
      wait_busy(1'b0);
      wait_busy(1'b1);
      check("gap_55_aa", last_gap, 1);
      p_data = 8'h55;
      push(8'h55, 1'b0, 1'b0);
      wait_busy(1'b0);
      wait_busy(1'b1);
      check("gap_aa_55", last_gap, 1);
      data_valid = 1'b0;
      wait_done();

      // reset during data bit 3 abandons the frame
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (4 * CPB) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midreset_tx_out", int'(tx_out), 1);
      check("midreset_busy", int'(busy), 0);
      @(negedge clk); #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_queue_dropped", exp_q.size(), 0);
      send(8'h5A, 1'b1, 1'b1, 1'b1);
      wait_done();

      check("idle_line_high", idle_bad, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
